// File: rtl/player_motion_ctrl_if.sv
// Button/enable inputs and position/status outputs of the player motion controller.
interface player_motion_ctrl_if #(
  parameter int POS_W = 10
);
  logic             enable;
  logic             left_button;
  logic             right_button;
  logic [POS_W-1:0] player_x;
  logic [POS_W-1:0] player_y;
  logic             step_pulse;
  logic             at_left_edge;
  logic             at_right_edge;

  // Driver side: buttons and enable out, position and status in
  modport master (
    output enable, left_button, right_button,
    input  player_x, player_y, step_pulse, at_left_edge, at_right_edge
  );

  // Controller side
  modport slave (
    input  enable, left_button, right_button,
    output player_x, player_y, step_pulse, at_left_edge, at_right_edge
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player motion controller: two active-low buttons -> clamped horizontal
// position. Each button is synchronised and debounced; a press steps once,
// and holding it auto-repeats after an initial delay.
module player_motion_ctrl #(
  parameter int POS_W         = 10,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int PLAYER_W      = 32,
  parameter int PLAYER_H      = 16,
  parameter int MARGIN_Y      = 4,
  parameter int STEP          = 4,
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 1250000,
  parameter int CNT_W         = 32
) (
  input logic                 CLOCK_50,
  input logic                 reset,
  player_motion_ctrl_if.slave bus
);

  localparam logic [POS_W-1:0] MAX_X    = POS_W'(SCREEN_W - PLAYER_W);
  localparam logic [POS_W-1:0] START_X  = POS_W'((SCREEN_W - PLAYER_W) / 2);
  localparam logic [POS_W-1:0] PLAYER_Y = POS_W'(SCREEN_H - MARGIN_Y - PLAYER_H);
  localparam logic [POS_W-1:0] STEP_X   = POS_W'(STEP);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  // index 0 = left, 1 = right; raw levels are active low
  logic [1:0] raw;
  logic [1:0] press;
  assign raw = {bus.right_button, bus.left_button};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             pressed_reg;
      logic             lock_reg;
      logic [CNT_W-1:0] db_cnt_reg;
      logic [CNT_W-1:0] rel_cnt_reg;

      // Synchronise, debounce, and hold off any press that was already
      // down at reset until the button has been seen cleanly released.
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          pressed_reg <= 1'b0;
          lock_reg    <= 1'b1;
          db_cnt_reg  <= '0;
          rel_cnt_reg <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (!sync2_reg != pressed_reg) begin
            if (db_cnt_reg == DB_LAST) begin
              pressed_reg <= !sync2_reg;
              db_cnt_reg  <= '0;
            end else begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
          end else begin
            db_cnt_reg <= '0;
          end
          if (!sync2_reg) begin
            rel_cnt_reg <= '0;
          end else if (rel_cnt_reg == DB_LAST) begin
            lock_reg <= 1'b0;
          end else begin
            rel_cnt_reg <= rel_cnt_reg + 1'b1;
          end
        end
      end

      assign press[gi] = pressed_reg & ~lock_reg;
    end
  endgenerate

  state_t           state_reg;
  logic [CNT_W-1:0] timer_reg;
  logic [POS_W-1:0] x_reg;
  logic             pulse_reg;
  logic             dir_left_reg;

  logic [POS_W-1:0] left_x;
  logic [POS_W-1:0] right_x;
  logic             go_left;
  logic [POS_W-1:0] step_x;
  logic             hold_ok;
  logic [CNT_W-1:0] timer_last;

  assign left_x     = (x_reg >= STEP_X) ? x_reg - STEP_X : '0;
  assign right_x    = (x_reg <= MAX_X - STEP_X) ? x_reg + STEP_X : MAX_X;
  assign go_left    = (state_reg == IDLE) ? press[0] : dir_left_reg;
  assign step_x     = go_left ? left_x : right_x;
  assign hold_ok    = bus.enable && (dir_left_reg ? (press[0] && !press[1])
                                                  : (press[1] && !press[0]));
  assign timer_last = (state_reg == DELAY) ? DLY_LAST : RPT_LAST;

  // Press / delay / repeat sequencing with registered position and strobe
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      x_reg        <= START_X;
      pulse_reg    <= 1'b0;
      dir_left_reg <= 1'b0;
    end else begin
      pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.enable && (press[0] ^ press[1])) begin
            dir_left_reg <= press[0];
            timer_reg    <= '0;
            state_reg    <= DELAY;
            x_reg        <= step_x;
            pulse_reg    <= (step_x != x_reg);
          end
        end
        default: begin
          if (!hold_ok) begin
            state_reg <= IDLE;
            timer_reg <= '0;
          end else if (timer_reg == timer_last) begin
            state_reg <= REPEAT;
            timer_reg <= '0;
            x_reg     <= step_x;
            pulse_reg <= (step_x != x_reg);
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.player_x      = x_reg;
  assign bus.player_y      = PLAYER_Y;
  assign bus.step_pulse    = pulse_reg;
  assign bus.at_left_edge  = (x_reg == '0);
  assign bus.at_right_edge = (x_reg == MAX_X);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus random button
// traffic, compared every cycle against a behavioural model.
module tb_player_motion_ctrl;
  localparam int SW = 64, PW = 8, ST = 4, DB = 4, RD = 20, RP = 5;
  localparam int MAXX = SW - PW;
  localparam int STARTX = (SW - PW) / 2;
  localparam int PY = 480 - 4 - 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, lb, rb;
  int checks = 0;
  int failures = 0;
  int pulse_seen = 0;

  player_motion_ctrl_if #(.POS_W(10)) bus ();
  assign bus.enable       = en;
  assign bus.left_button  = lb;
  assign bus.right_button = rb;

  player_motion_ctrl #(
    .POS_W(10), .SCREEN_W(SW), .SCREEN_H(480), .PLAYER_W(PW), .PLAYER_H(16),
    .MARGIN_Y(4), .STEP(ST), .DEBOUNCE_CYC(DB), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(32)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst),
    .bus(bus)
  );

  // behavioural model state
  int mx;
  bit m_pulse;
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_pressed [2];
  bit m_lock [2];
  bit hist [2][$];
  int m_held;   // 0 none, 1 left, 2 right
  int m_age;    // cycles since the press that started the hold

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs now applied
  task automatic model_tick();
    bit l, r, step, all0, all1, rawb, old_s2;
    int nx;
    if (rst) begin
      mx = STARTX; m_pulse = 0; m_held = 0; m_age = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_pressed[b] = 0; m_lock[b] = 1;
        hist[b].delete();
      end
      return;
    end
    l = m_pressed[0] && !m_lock[0];
    r = m_pressed[1] && !m_lock[1];
    step = 0;
    if (m_held != 0) begin
      if (en && (l ^ r) && ((l ? 1 : 2) == m_held)) begin
        m_age++;
        if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) step = 1;
      end else begin
        m_held = 0;
      end
    end else if (en && (l ^ r)) begin
      m_held = l ? 1 : 2;
      m_age = 0;
      step = 1;
    end
    m_pulse = 0;
    if (step) begin
      if (m_held == 1) nx = (mx - ST < 0) ? 0 : mx - ST;
      else             nx = (mx + ST > MAXX) ? MAXX : mx + ST;
      m_pulse = (nx != mx);
      mx = nx;
    end
    // button acceptance: last DB synchronised samples all agree
    for (int b = 0; b < 2; b++) begin
      rawb = (b == 0) ? lb : rb;
      old_s2 = m_s2[b];
      m_s2[b] = m_s1[b];
      m_s1[b] = rawb;
      hist[b].push_back(old_s2);
      if (hist[b].size() > DB) void'(hist[b].pop_front());
      if (hist[b].size() == DB) begin
        all0 = 1; all1 = 1;
        foreach (hist[b][k]) begin
          if (hist[b][k]) all0 = 0; else all1 = 0;
        end
        if (all1) begin m_pressed[b] = 0; m_lock[b] = 0; end
        if (all0) m_pressed[b] = 1;
      end
    end
  endtask

  task automatic cyc();
    model_tick();
    @(posedge clk);
    #1;
    check("player_x", bus.player_x, mx);
    check("step_pulse", bus.step_pulse, m_pulse);
    check("at_left_edge", bus.at_left_edge, mx == 0);
    check("at_right_edge", bus.at_right_edge, mx == MAXX);
    check("player_y", bus.player_y, PY);
    if (bus.step_pulse) pulse_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst = 1; en = 1; lb = 1; rb = 1;
    run(3);
    check("reset_x", bus.player_x, 28);
    check("reset_pulse", bus.step_pulse, 0);
    check("reset_edges", {bus.at_left_edge, bus.at_right_edge}, 0);
    rst = 0;
    run(12);
    // short glitch is ignored
    lb = 0; run(2); lb = 1; run(12);
    check("glitch_x", bus.player_x, 28);
    // single tap
    pulse_seen = 0;
    lb = 0; run(10); lb = 1; run(15);
    check("tap_x", bus.player_x, 24);
    check("tap_pulses", pulse_seen, 1);
    // hold right: first step, delay, repeats
    rb = 0; run(60); rb = 1; run(15);
    // left into the clamp and right into the clamp
    lb = 0; run(200); lb = 1; run(15);
    check("left_clamp_x", bus.player_x, 0);
    check("left_clamp_edge", bus.at_left_edge, 1);
    rb = 0; run(200); rb = 1; run(15);
    check("right_clamp_x", bus.player_x, MAXX);
    check("right_clamp_edge", bus.at_right_edge, 1);
    // both pressed, then release right, then drop enable mid-repeat
    lb = 0; rb = 0; run(30);
    rb = 1; run(40);
    en = 0; run(15);
    en = 1; run(10);
    lb = 1; run(15);
    // reset during repeat while left stays held
    lb = 0; run(40);
    rst = 1; run(2); rst = 0;
    run(60);
    check("reset_hold_x", bus.player_x, 28);
    lb = 1; run(15);
    lb = 0; run(12); lb = 1; run(15);
    check("repress_x", bus.player_x, 24);
    // random traffic
    for (int s = 0; s < 150; s++) begin
      lb  = ($urandom_range(0, 99) < 50) ? 1'b0 : 1'b1;
      rb  = ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1;
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 49) == 0);
      run(rst ? 2 : $urandom_range(1, 40));
      rst = 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
